imem_fetch_unit: RTL and testbench
==================================

Name: imem_fetch_unit

Overview:
- Parametrised, synchronous instruction memory for the RISC-V core, with a request/response handshake and a configurable number of wait states.
- Includes a program-load write port and pre-sliced decode fields; RISC-V formats: op, rd, funct3, rs1, rs2, funct7, I/S/B immediates.
- Reports misaligned and out-of-range fetches.
- Sits between the PC/fetch stage and the decoder; replaces the fixed 16-word combinational ROM.

Parameters:
- DEPTH, 64, number of 32-bit words; power of two, ≥ 4.
- LATENCY, 1, cycles from request acceptance to rsp_valid; 1..8.
- NOP_WORD, 32'h00000013, instruction returned on any fault.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  request can be accepted this cycle.
- pc  in  32  byte address of the fetch.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts the response.
- instr  out  32  fetched word, or NOP_WORD on fault.
- op  out  7  instr[6:0].
- rd  out  5  instr[11:7].
- funct3  out  3  instr[14:12].
- rs1  out  5  instr[19:15].
- rs2  out  5  instr[24:20].
- funct7  out  7  instr[31:25].
- i_imm  out  12  instr[31:20].
- s_imm  out  12  {instr[31:25], instr[11:7]}.
- b_imm  out  13  {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
- fault  out  1  response is a faulted fetch.
- fault_code  out  2  0 = none, 1 = misaligned, 2 = out of range.
- wr_en  in  1  program-load write strobe.
- wr_addr  in  32  byte address of the write.
- wr_data  in  32  word to write.
- halted  out  1  halt word seen (only with the optional feature).

Behaviour:
- Reset (async, active-high):
  - state = IDLE, rsp_valid = 0, instr = NOP_WORD, fault = 0, fault_code = 0, halted = 0, wait counter = 0.
  - Memory contents are not affected by reset; they are undefined until written.
- States:
  - IDLE: req_ready = 1.
  - BUSY: counting LATENCY-1 wait states; req_ready = 0.
  - DONE: rsp_valid = 1; req_ready = rsp_ready.
- Accept occurs when req_valid && req_ready. The memory word and the fault classification are captured into the response register at the accepting edge.
- IDLE transitions:
  - accept with LATENCY = 1 → DONE.
  - accept with LATENCY > 1 → BUSY with counter = LATENCY-1.
- BUSY: counter decrements each cycle; at 1 → DONE. rsp_valid rises exactly LATENCY cycles after the accepting edge.
- DONE transitions:
  - rsp_ready = 0: hold the response; all outputs stay stable.
  - rsp_ready = 1, no new accept → IDLE, rsp_valid = 0.
  - rsp_ready = 1 with a new accept → the new request is accepted in the same cycle and follows the IDLE transitions. With LATENCY = 1 this gives one fetch per cycle.
- Fault classification:
  - pc[1:0] != 0 → code 1.
  - else pc[31:2] ≥ DEPTH → code 2.
  - Misaligned takes priority over out of range.
  - A faulted response has instr = NOP_WORD and decode fields sliced from NOP_WORD.
- Write port:
  - Independent of fetch state. The write takes effect at the clock edge when wr_en = 1.
  - wr_addr with bits[1:0] != 0, or word index ≥ DEPTH, → write silently dropped.
- Same-cycle write and accept to the same word: the fetch returns the old contents. Writes after acceptance never alter an in-flight response.
- Reset mid-operation: the in-flight request is dropped, no response is issued, and the block returns to IDLE.
- Decode fields are pure slices of the registered instr and change only when instr changes.

Optional Feature:
- Macro: IMEM_HALT_DETECT_EN.
- Defined:
  - A non-faulted response with instr == 32'hFC000000 sets halted = 1 in the cycle rsp_valid rises.
  - halted is sticky until reset.
  - While halted = 1, req_ready = 0.
  - The halt response itself is delivered normally.
- Undefined: halted is tied 0, and 32'hFC000000 is returned as an ordinary word.

Test Plan:
- Load 32'h00808113 at 0x4; fetch pc = 0x4 with LATENCY = 2 → rsp_valid rises 2 cycles after accept; op = 0x13, rd = 2, rs1 = 1, funct3 = 0, i_imm = 12'h008, fault = 0.
- Load 32'h00021163 at 0xC; fetch pc = 0xC → op = 0x63, funct3 = 1, rs1 = 4, rs2 = 0, b_imm = 13'h0002.
- LATENCY = 1, rsp_ready = 1, req_valid held high, pc = 0, 4, 8 → three responses on consecutive cycles in order. Then rsp_ready = 0 for 3 cycles → instr and rsp_valid held stable, req_ready = 0.
- Fetch pc = 0x6 → fault = 1, fault_code = 1, instr = 32'h00000013. Fetch pc = DEPTH*4 → fault_code = 2. Write to wr_addr = DEPTH*4 → memory unchanged.
- Same cycle: write 32'hDEADBEEF to 0x8 and accept fetch of 0x8, which holds 32'h00412133 → response 32'h00412133; next fetch of 0x8 → 32'hDEADBEEF.
- LATENCY = 4: assert reset 2 cycles after accept → rsp_valid stays 0 and req_ready = 1 after release. With IMEM_HALT_DETECT_EN, fetch of 32'hFC000000 → halted = 1 and req_ready stays 0 until reset.

Source files
------------

// File: rtl/imem_fetch_unit_if.sv
// Fetch-side bus of the instruction memory: request/response handshake,
// pre-sliced decode fields, fault report and the program-load write port.
interface imem_fetch_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] pc;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] instr;
  logic [6:0]  op;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;
  logic [11:0] i_imm;
  logic [11:0] s_imm;
  logic [12:0] b_imm;
  logic        fault;
  logic [1:0]  fault_code;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        halted;

  modport master (
    output req_valid, pc, rsp_ready, wr_en, wr_addr, wr_data,
    input  req_ready, rsp_valid, instr, op, rd, funct3, rs1, rs2, funct7,
           i_imm, s_imm, b_imm, fault, fault_code, halted
  );

  modport slave (
    input  req_valid, pc, rsp_ready, wr_en, wr_addr, wr_data,
    output req_ready, rsp_valid, instr, op, rd, funct3, rs1, rs2, funct7,
           i_imm, s_imm, b_imm, fault, fault_code, halted
  );
endinterface

// File: rtl/imem_fetch_unit.sv
// Instruction memory with req/rsp handshake, LATENCY-cycle response, fault
// classification and program-load port. IMEM_HALT_DETECT_EN enables halt-word detection.
module imem_fetch_unit #(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned LATENCY  = 1,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input logic              clk,
  input logic              reset,
  imem_fetch_unit_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   mem [DEPTH];
  logic [31:0]   instr_q;
  logic          fault_q;
  logic [1:0]    code_q;
  logic          rsp_valid_q;
  logic          halted_q;
  logic          req_ready;
  logic          accept;
  logic [1:0]    nxt_code;
  logic [31:0]   nxt_instr;
  logic          wr_ok;

  // Misaligned wins over out-of-range; faulted fetches never touch the array.
  always_comb begin
    nxt_code = 2'd0;
    if (bus.pc[1:0] != 2'b00)          nxt_code = 2'd1;
    else if (bus.pc[31:AW+2] != '0)    nxt_code = 2'd2;
    nxt_instr = (nxt_code == 2'd0) ? mem[bus.pc[AW+1:2]] : NOP_WORD;
  end

  always_comb begin
    req_ready = 1'b0;
    unique case (state)
      IDLE:    req_ready = 1'b1;
      DONE:    req_ready = bus.rsp_ready;
      default: req_ready = 1'b0;
    endcase
    if (halted_q) req_ready = 1'b0;
  end

  assign accept = bus.req_valid && req_ready;
  assign wr_ok  = bus.wr_en && (bus.wr_addr[1:0] == 2'b00) && (bus.wr_addr[31:AW+2] == '0);

  // Array read happens in the FSM on the accepting edge, so a same-edge write is not seen.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[bus.wr_addr[AW+1:2]] <= bus.wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      rsp_valid_q <= 1'b0;
      instr_q     <= NOP_WORD;
      fault_q     <= 1'b0;
      code_q      <= 2'd0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (accept) begin
            instr_q <= nxt_instr;
            fault_q <= (nxt_code != 2'd0);
            code_q  <= nxt_code;
            if (LATENCY == 1) begin
              state       <= DONE;
              rsp_valid_q <= 1'b1;
            end else begin
              state       <= BUSY;
              rsp_valid_q <= 1'b0;
              cnt         <= CW'(LATENCY - 1);
            end
          end else if (state == DONE && bus.rsp_ready) begin
            state       <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        BUSY: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state       <= DONE;
            rsp_valid_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IMEM_HALT_DETECT_EN
  localparam logic [31:0] HALT_WORD = 32'hFC00_0000;
  logic        rise;
  logic [31:0] rise_instr;

  // Word about to become visible on rsp_valid's rising edge; faults carry NOP so never match.
  always_comb begin
    rise       = 1'b0;
    rise_instr = instr_q;
    if (state == BUSY && cnt == CW'(1)) begin
      rise = 1'b1;
    end else if (accept && LATENCY == 1) begin
      rise       = 1'b1;
      rise_instr = nxt_instr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                halted_q <= 1'b0;
    else if (rise && rise_instr == HALT_WORD) halted_q <= 1'b1;
  end
`else
  assign halted_q = 1'b0;
`endif

  assign bus.req_ready  = req_ready;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.instr      = instr_q;
  assign bus.op         = instr_q[6:0];
  assign bus.rd         = instr_q[11:7];
  assign bus.funct3     = instr_q[14:12];
  assign bus.rs1        = instr_q[19:15];
  assign bus.rs2        = instr_q[24:20];
  assign bus.funct7     = instr_q[31:25];
  assign bus.i_imm      = instr_q[31:20];
  assign bus.s_imm      = {instr_q[31:25], instr_q[11:7]};
  assign bus.b_imm      = {instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
  assign bus.fault      = fault_q;
  assign bus.fault_code = code_q;
  assign bus.halted     = halted_q;
endmodule

// File: tb/tb_imem_fetch_unit.sv
// Scoreboard bench for imem_fetch_unit: three instances (LATENCY 1, 2, 4) share
// clock, reset and the load port; directed fetches push expectations, a monitor pops.
module tb_imem_fetch_unit;
  localparam int          DEPTH  = 64;
  localparam int          LAT[3] = '{1, 2, 4};
  localparam logic [31:0] NOP    = 32'h0000_0013;
`ifdef IMEM_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  typedef struct packed {
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] instr;
    logic        fault;
    logic [1:0]  code;
    logic        halted;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  f7;
    logic [11:0] i_imm;
    logic [11:0] s_imm;
    logic [12:0] b_imm;
  } obs_t;

  typedef struct {
    int          k;
    logic [31:0] instr;
    logic [1:0]  code;
    int          due;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid[3];
  logic        rsp_ready[3];
  logic [31:0] pc[3];
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  obs_t        obs[3];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  ent_t        sbq[$];
  bit          seen = 1'b0;

  imem_fetch_unit_if bus[3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign bus[g].req_valid = req_valid[g];
    assign bus[g].pc        = pc[g];
    assign bus[g].rsp_ready = rsp_ready[g];
    assign bus[g].wr_en     = wr_en;
    assign bus[g].wr_addr   = wr_addr;
    assign bus[g].wr_data   = wr_data;
    assign obs[g] = {bus[g].req_ready, bus[g].rsp_valid, bus[g].instr, bus[g].fault,
                     bus[g].fault_code, bus[g].halted, bus[g].op, bus[g].rd, bus[g].funct3,
                     bus[g].rs1, bus[g].rs2, bus[g].funct7, bus[g].i_imm, bus[g].s_imm,
                     bus[g].b_imm};
    imem_fetch_unit #(.DEPTH(DEPTH), .LATENCY(LAT[g]), .NOP_WORD(NOP)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus[g])
    );
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every cycle a response is visible it must match the head entry.
  always @(negedge clk) begin
    ent_t e;
    for (int k = 0; k < 3; k++) begin
      if (!reset && obs[k].rsp_valid) begin
        if (sbq.size() == 0 || sbq[0].k != k) begin
          chk("unexpected_rsp", 64'(k + 1), 64'(0));
        end else begin
          e = sbq[0];
          if (!seen) begin
            chk("latency", 64'(cyc), 64'(e.due));
            seen = 1'b1;
          end
          chk("instr", 64'(obs[k].instr), 64'(e.instr));
          chk("fault", 64'({obs[k].fault, obs[k].code}), 64'({e.code != 2'd0, e.code}));
          chk("decode", 64'({obs[k].op, obs[k].rd, obs[k].f3, obs[k].rs1, obs[k].rs2, obs[k].f7}),
              64'({e.instr[6:0], e.instr[11:7], e.instr[14:12], e.instr[19:15],
                   e.instr[24:20], e.instr[31:25]}));
          chk("imm", 64'({obs[k].i_imm, obs[k].s_imm, obs[k].b_imm}),
              64'({e.instr[31:20], e.instr[31:25], e.instr[11:7], e.instr[31], e.instr[7],
                   e.instr[30:25], e.instr[11:8], 1'b0}));
          if (rsp_ready[k]) begin
            void'(sbq.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  task automatic fetch(input int k, input logic [31:0] a, input logic [31:0] ei,
                       input logic [1:0] ec, input bit hold);
    int   n = 0;
    ent_t e;
    req_valid[k] = 1'b1;
    pc[k]        = a;
    @(negedge clk);
    while (!obs[k].req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!obs[k].req_ready) begin
      chk("req_timeout", 64'(0), 64'(1));
    end else begin
      e.k = k; e.instr = ei; e.code = ec; e.due = cyc + LAT[k];
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    if (!hold) req_valid[k] = 1'b0;
  endtask

  task automatic wait_rsp(input int k);
    int n = 0;
    while (!obs[k].rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!obs[k].rsp_valid) chk("rsp_timeout", 64'(0), 64'(1));
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      req_valid[k] = 1'b0; rsp_ready[k] = 1'b1; pc[k] = '0;
    end
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++)
      chk("reset_state",
          64'({obs[k].rsp_valid, obs[k].req_ready, obs[k].instr, obs[k].fault, obs[k].code, obs[k].halted}),
          64'({1'b0, 1'b1, NOP, 1'b0, 2'd0, 1'b0}));
    @(posedge clk); #1;
    reset = 1'b0;

    wr(32'h0,   32'h0000_0093);
    wr(32'h4,   32'h0080_8113);
    wr(32'h8,   32'h0041_2133);
    wr(32'hC,   32'h0002_1163);
    wr(32'h10,  32'hFC00_0000);
    wr(32'(DEPTH * 4), 32'hBAD0_BAD0);  // out of range: must not alias word 0
    wr(32'hE,   32'h1234_5678);         // misaligned: must not touch word 3

    // LATENCY = 2 fetch with hand-decoded fields
    fetch(1, 32'h4, 32'h0080_8113, 2'd0, 1'b0);
    wait_rsp(1);
    chk("addi_fields", 64'({obs[1].op, obs[1].rd, obs[1].f3, obs[1].rs1, obs[1].i_imm, obs[1].fault}),
        64'({7'h13, 5'd2, 3'd0, 5'd1, 12'h008, 1'b0}));
    repeat (2) @(posedge clk); #1;

    fetch(0, 32'hC, 32'h0002_1163, 2'd0, 1'b0);
    wait_rsp(0);
    chk("bne_fields", 64'({obs[0].op, obs[0].f3, obs[0].rs1, obs[0].rs2, obs[0].b_imm}),
        64'({7'h63, 3'd1, 5'd4, 5'd0, 13'h0002}));
    @(posedge clk); #1;

    // back-to-back at one per cycle, then backpressure
    fetch(0, 32'h0, 32'h0000_0093, 2'd0, 1'b1);
    fetch(0, 32'h4, 32'h0080_8113, 2'd0, 1'b1);
    fetch(0, 32'h8, 32'h0041_2133, 2'd0, 1'b0);
    rsp_ready[0] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("hold_valid_ready", 64'({obs[0].rsp_valid, obs[0].req_ready}), 64'(2'b10));
    end
    @(posedge clk); #1;
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;

    // faults and dropped writes
    fetch(0, 32'h6, NOP, 2'd1, 1'b0);
    fetch(0, 32'(DEPTH * 4), NOP, 2'd2, 1'b0);
    fetch(0, 32'(DEPTH * 4 + 2), NOP, 2'd1, 1'b0);
    fetch(0, 32'hFFFF_FFF0, NOP, 2'd2, 1'b0);
    fetch(0, 32'h0, 32'h0000_0093, 2'd0, 1'b0);
    fetch(0, 32'hC, 32'h0002_1163, 2'd0, 1'b0);

    // write and accept on the same edge return old data
    wr_en = 1'b1; wr_addr = 32'h8; wr_data = 32'hDEAD_BEEF;
    fetch(0, 32'h8, 32'h0041_2133, 2'd0, 1'b0);
    wr_en = 1'b0;
    fetch(0, 32'h8, 32'hDEAD_BEEF, 2'd0, 1'b0);
    @(posedge clk); #1;

    // halt word
    fetch(0, 32'h10, 32'hFC00_0000, 2'd0, 1'b0);
    wait_rsp(0);
    chk("halted_on_rise", 64'(obs[0].halted), 64'(HALT_EN));
    @(posedge clk); #1;
    repeat (2) begin
      @(negedge clk);
      chk("halt_req_ready", 64'({obs[0].req_ready, obs[0].halted}), 64'({!HALT_EN, HALT_EN}));
    end
    @(posedge clk); #1;

    // LATENCY = 4, reset two cycles after accept drops the request
    fetch(2, 32'h4, 32'h0080_8113, 2'd0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    sbq.delete();
    seen = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", 64'(obs[2].rsp_valid), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("rst_drop", 64'({obs[2].rsp_valid, obs[2].req_ready}), 64'(2'b01));
    end
    chk("halt_cleared", 64'({obs[0].halted, obs[0].req_ready}), 64'(2'b01));

    chk("sb_drain", 64'(sbq.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, %0d miscompares so far", n_err);
    $fatal(1);
  end
endmodule
